// File: rtl/dmem_lsu_if.sv
// ----------------------------------------------------------------------------
// dmem_lsu_if
// Bundles the core-facing request/response handshake and the DMEM requester
// port of the load/store unit.
//   slave  : LSU view (takes core requests, drives DMEM strobes/address/data)
//   master : environment view (core + DMEM)
// Signals
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//   resp_valid/resp_rdata/resp_fault                          core response
//   memread/memwrite/data_type/addr/wr_data/out_data          DMEM port
// ----------------------------------------------------------------------------
interface dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        memread;
    logic        memwrite;
    logic [1:0]  data_type;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] out_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, out_data,
        output req_ready, resp_valid, resp_rdata, resp_fault,
               memread, memwrite, data_type, addr, wr_data
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, out_data,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
               memread, memwrite, data_type, addr, wr_data
    );
endinterface

// File: rtl/dmem_lsu.sv
// ----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit on the requester side of the DMEM port. Accepts one RV32I
// load/store per handshake, issues it to DMEM, extends load data and returns
// a one-cycle response pulse. Every address is range-checked against the
// DMEM window; bad funct3 encodings fault without touching DMEM.
//
// Parameters
//   DMEM_BASE  first byte address of the DMEM window
//   DMEM_SIZE  window size in bytes (power of two)
//   READ_LAT   cycles from memread strobe to valid out_data (1..4)
// Ports
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   bus        dmem_lsu_if.slave (core handshake + DMEM port)
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  defined: misaligned H/W accesses fault.
//                         undefined: address is forced aligned and the access
//                         completes normally.
// ----------------------------------------------------------------------------
module dmem_lsu #(
    parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
    parameter logic [31:0] DMEM_SIZE = 32'h0000_1000,
    parameter int          READ_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_lsu_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // End of window computed in 33 bits so the top of the address space
    // cannot wrap back into the window.
    localparam logic [32:0] WIN_END  = {1'b0, DMEM_BASE} + {1'b0, DMEM_SIZE};
    localparam logic [2:0]  LAST_CNT = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic        fault_q;
    logic [2:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  dtype_q;
    logic [31:0] rdata_q;

    // ---------------- accept-time decode / fault check ----------------
    logic [2:0]  acc_size;
    logic        bad_funct3;
    logic        misalign;
    logic        align_fault;
    logic [31:0] eff_addr;
    logic [32:0] acc_end;
    logic        range_fault;
    logic        acc_fault;
    logic        accept;

    always_comb begin
        acc_size = 3'd4;
        case (bus.req_funct3[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
    end

    // 011 plus the 11x group are not RV32I load/store widths.
    assign bad_funct3 = (bus.req_funct3[1:0] == 2'b11) || (bus.req_funct3[2:1] == 2'b11);
    assign misalign   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
    assign align_fault = misalign;
    assign eff_addr    = bus.req_addr;
`else
    assign align_fault = 1'b0;
    always_comb begin
        eff_addr = bus.req_addr;
        if (bus.req_funct3[1:0] == 2'b01)
            eff_addr[0] = 1'b0;
        else if (bus.req_funct3[1:0] == 2'b10)
            eff_addr[1:0] = 2'b00;
    end
`endif

    assign acc_end     = {1'b0, eff_addr} + {30'b0, acc_size};
    assign range_fault = (eff_addr < DMEM_BASE) || (acc_end > WIN_END);
    assign acc_fault   = bad_funct3 || align_fault || range_fault;
    assign accept      = (state_q == IDLE) && bus.req_valid;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset drops them in the same instant.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = 1'b0;
        bus.memread    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_d = acc_fault ? RESP : ISSUE;
            end
            ISSUE: begin
                bus.memwrite = we_q;
                bus.memread  = !we_q;
                state_d      = we_q ? RESP : WAIT;
            end
            WAIT: begin
                bus.memread = 1'b1;
                if (cnt_q == LAST_CNT)
                    state_d = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- load data extension ----------------
    logic [31:0] ext_data;
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   ext_data = {{24{~funct3_q[2] & bus.out_data[7]}},  bus.out_data[7:0]};
            2'b01:   ext_data = {{16{~funct3_q[2] & bus.out_data[15]}}, bus.out_data[15:0]};
            default: ext_data = bus.out_data;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b010;
            fault_q  <= 1'b0;
            cnt_q    <= 3'd0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            dtype_q  <= 2'd2;
            rdata_q  <= 32'h0;
        end else begin
            if (accept) begin
                we_q     <= bus.req_we;
                funct3_q <= bus.req_funct3;
                fault_q  <= acc_fault;
                cnt_q    <= 3'd0;
                rdata_q  <= 32'h0;
                // Faulted accesses never reach DMEM, so the bus keeps its
                // previous address/data.
                if (!acc_fault) begin
                    addr_q  <= eff_addr;
                    wdata_q <= bus.req_wdata;
                    dtype_q <= bus.req_funct3[1:0];
                end
            end
            if (state_q == WAIT) begin
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == LAST_CNT)
                    rdata_q <= ext_data;
            end
        end
    end

    assign bus.addr       = addr_q;
    assign bus.wr_data    = wdata_q;
    assign bus.data_type  = dtype_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q && (state_q == RESP);

endmodule

// File: tb/tb_dmem_lsu.sv
// ----------------------------------------------------------------------------
// tb_dmem_lsu
// Drives two LSUs (READ_LAT 1 and 3) with identical requests, each attached
// to its own byte-array DMEM model whose out_data is only valid on the cycle
// the LSU is due to sample it. Expected responses come from a request-level
// reference model holding its own copy of memory.
// ----------------------------------------------------------------------------
module tb_dmem_lsu;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;
    localparam int RL [2] = '{1, 3};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;

    dmem_lsu_if b1();
    dmem_lsu_if b3();

    dmem_lsu #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .READ_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_lsu #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .READ_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    assign b1.req_valid = req_valid;  assign b3.req_valid = req_valid;
    assign b1.req_we    = req_we;     assign b3.req_we    = req_we;
    assign b1.req_funct3 = req_f3;    assign b3.req_funct3 = req_f3;
    assign b1.req_addr  = req_addr;   assign b3.req_addr  = req_addr;
    assign b1.req_wdata = req_wdata;  assign b3.req_wdata = req_wdata;

    logic        rv [2], rf [2], mr [2], mw [2], rdy [2];
    logic [31:0] rd [2], ad [2], wdo [2], od [2];
    logic [1:0]  dt [2];
    assign rv[0] = b1.resp_valid;  assign rv[1] = b3.resp_valid;
    assign rf[0] = b1.resp_fault;  assign rf[1] = b3.resp_fault;
    assign mr[0] = b1.memread;     assign mr[1] = b3.memread;
    assign mw[0] = b1.memwrite;    assign mw[1] = b3.memwrite;
    assign rdy[0] = b1.req_ready;  assign rdy[1] = b3.req_ready;
    assign rd[0] = b1.resp_rdata;  assign rd[1] = b3.resp_rdata;
    assign ad[0] = b1.addr;        assign ad[1] = b3.addr;
    assign wdo[0] = b1.wr_data;    assign wdo[1] = b3.wr_data;
    assign dt[0] = b1.data_type;   assign dt[1] = b3.data_type;
    assign b1.out_data = od[0];    assign b3.out_data = od[1];

    // ---------------- DMEM models ----------------
    logic [7:0] mem [2][4096];
    int         rdcnt [2];
    logic       mem_init;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    function automatic int nbytes(input logic [1:0] t);
        return (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                rdcnt[d] <= 0;
                for (int i = 0; i < 4096; i++) mem[d][i] <= init_byte(i);
            end else begin
                rdcnt[d] <= mr[d] ? rdcnt[d] + 1 : 0;
                if (mw[d]) begin
                    for (int k = 0; k < 4; k++) begin
                        int off;
                        off = int'(ad[d] - BASE) + k;
                        if (k < nbytes(dt[d]) && ad[d] >= BASE && off < 4096)
                            mem[d][off[11:0]] <= wdo[d][8*k +: 8];
                    end
                end
            end
        end
    end

    // Read data only shows up on the cycle the requester is due to sample.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            logic [31:0] w;
            int off;
            w = 32'h0;
            off = 0;
            od[d] = 32'hDEAD_BEEF;
            if (mr[d] && rdcnt[d] == RL[d]) begin
                for (int k = 0; k < 4; k++) begin
                    off = int'(ad[d] - BASE) + k;
                    if (k < nbytes(dt[d]) && ad[d] >= BASE && off < 4096)
                        w[8*k +: 8] = mem[d][off[11:0]];
                end
                od[d] = w;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] refmem [4096];
    int vec = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic flt,
                             output logic [31:0] ea, output logic [31:0] rdata);
        longint sz, la, lea, v;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        flt = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        la  = longint'(a);
`ifdef LSU_MISALIGN_TRAP_EN
        if (la % sz != 0) flt = 1'b1;
        lea = la;
`else
        lea = la - (la % sz);
`endif
        ea = lea[31:0];
        if (lea < longint'(BASE) || lea + sz > longint'(BASE) + longint'(SIZE)) flt = 1'b1;
        rdata = 32'h0;
        if (!flt) begin
            if (we) begin
                for (longint k = 0; k < sz; k++) refmem[lea - longint'(BASE) + k] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (longint k = 0; k < sz; k++) v = v + (longint'(refmem[lea - longint'(BASE) + k]) << (8 * k));
                if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
                rdata = v[31:0];
            end
        end
    endtask

    // One transaction on both LSUs; got returns the READ_LAT=1 response data.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit probe_busy, output logic [31:0] got);
        logic flt;
        logic [31:0] ea, exp_rd;
        int resp_at [2], nresp [2], nrd [2], nwr [2], both [2], badaddr [2];
        logic [31:0] s_rd [2];
        logic s_flt [2];
        int lat;
        ref_model(we, f3, a, wd, flt, ea, exp_rd);
        for (int d = 0; d < 2; d++) begin
            resp_at[d] = 0; nresp[d] = 0; nrd[d] = 0; nwr[d] = 0; both[d] = 0; badaddr[d] = 0;
            s_rd[d] = 32'hX; s_flt[d] = 1'bX;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom; req_f3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (probe_busy && cyc == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = BASE; req_wdata = $urandom;
            end
            if (probe_busy && cyc == 3) req_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (rv[d]) begin
                    nresp[d]++;
                    if (resp_at[d] == 0) begin resp_at[d] = cyc; s_rd[d] = rd[d]; s_flt[d] = rf[d]; end
                end
                if (mr[d]) nrd[d]++;
                if (mw[d]) nwr[d]++;
                if (mr[d] && mw[d]) both[d]++;
                if ((mr[d] || mw[d]) && (ad[d] !== ea || dt[d] !== f3[1:0])) badaddr[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            string s;
            s = $sformatf("a=%08h f3=%0d we=%0d rl=%0d", a, f3, we, RL[d]);
            lat = flt ? 1 : (we ? 2 : 2 + RL[d]);
            chk({"resp_latency ", s}, resp_at[d], lat);
            chk({"resp_count ", s}, nresp[d], 1);
            chk({"resp_rdata ", s}, s_rd[d], exp_rd);
            chk({"resp_fault ", s}, {31'b0, s_flt[d]}, {31'b0, flt});
            chk({"memread_cycles ", s}, nrd[d], (flt || we) ? 0 : RL[d] + 1);
            chk({"memwrite_cycles ", s}, nwr[d], (!flt && we) ? 1 : 0);
            chk({"strobe_overlap ", s}, both[d], 0);
            chk({"strobe_addr_type ", s}, badaddr[d], 0);
            chk({"ready_after ", s}, {31'b0, rdy[d]}, 32'd1);
        end
        got = s_rd[0];
    endtask

    logic [31:0] got;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) refmem[i] = init_byte(i);
        req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
        mem_init = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ready d%0d", d), {31'b0, rdy[d]}, 32'd1);
            chk($sformatf("reset_resp d%0d", d), {29'b0, rv[d], rf[d], mr[d] | mw[d]}, 32'd0);
            chk($sformatf("reset_rdata d%0d", d), rd[d], 32'h0);
            chk($sformatf("reset_addr d%0d", d), ad[d], 32'h0);
            chk($sformatf("reset_wrdata d%0d", d), wdo[d], 32'h0);
            chk($sformatf("reset_dtype d%0d", d), {30'b0, dt[d]}, 32'd2);
        end
        mem_init = 1'b0;
        rst = 1'b0;

        // directed
        txn(1'b1, 3'b010, 32'h0010_0004, 32'h1234_5678, 1'b0, got);
        txn(1'b1, 3'b010, 32'h0010_0004, 32'h0000_0080, 1'b0, got);
        txn(1'b0, 3'b000, 32'h0010_0004, 32'h0, 1'b0, got);
        chk("lb_sign_ext", got, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h0010_0004, 32'h0, 1'b0, got);
        chk("lbu_zero_ext", got, 32'h0000_0080);
        txn(1'b1, 3'b010, 32'h0010_0004, 32'h0000_8001, 1'b0, got);
        txn(1'b0, 3'b001, 32'h0010_0004, 32'h0, 1'b0, got);
        chk("lh_sign_ext", got, 32'hFFFF_8001);
        txn(1'b0, 3'b101, 32'h0010_0004, 32'h0, 1'b0, got);
        chk("lhu_zero_ext", got, 32'h0000_8001);
        txn(1'b0, 3'b010, 32'h0000_000C, 32'h0, 1'b0, got);
        txn(1'b0, 3'b010, 32'h0010_0006, 32'h0, 1'b0, got);
        txn(1'b0, 3'b010, 32'h0010_0010, 32'h0, 1'b1, got);
        txn(1'b0, 3'b010, BASE + SIZE - 4, 32'h0, 1'b0, got);
        txn(1'b0, 3'b001, BASE + SIZE - 2, 32'h0, 1'b0, got);
        txn(1'b0, 3'b010, BASE + SIZE - 1, 32'h0, 1'b0, got);
        txn(1'b0, 3'b000, BASE + SIZE, 32'h0, 1'b0, got);
        txn(1'b0, 3'b000, BASE - 1, 32'h0, 1'b0, got);
        txn(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0, 1'b0, got);
        txn(1'b1, 3'b000, 32'hFFFF_FFFF, 32'hA5, 1'b0, got);
        txn(1'b0, 3'b011, 32'h0010_0000, 32'h0, 1'b0, got);
        txn(1'b1, 3'b110, 32'h0010_0000, 32'h1, 1'b0, got);
        txn(1'b0, 3'b111, 32'h0010_0000, 32'h0, 1'b0, got);

        // reset during WAIT of a load aborts it with no response
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h0010_0008;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_abort_strobe d%0d", d), {30'b0, mr[d], mw[d]}, 32'd0);
            chk($sformatf("rst_abort_ready d%0d", d), {31'b0, rdy[d]}, 32'd1);
        end
        begin
            int nresp_rst;
            nresp_rst = 0;
            repeat (2) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) nresp_rst += int'(rv[d]);
            end
            rst = 1'b0;
            repeat (5) begin
                @(negedge clk);
                for (int d = 0; d < 2; d++) nresp_rst += int'(rv[d] | mr[d]);
            end
            chk("rst_abort_no_resp", nresp_rst, 0);
        end
        txn(1'b0, 3'b010, 32'h0010_0008, 32'h0, 1'b0, got);

        // randomized
        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [2:0]  ld_tab [8];
            ld_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110};
            we = 1'($urandom);
            f3 = ld_tab[$urandom_range(0, 7)];
            if (we && f3[2] && f3 != 3'b110) f3 = {1'b0, f3[1:0]};
            case ($urandom_range(0, 5))
                0, 1, 2: a = BASE + ($urandom & (SIZE - 1));
                3:       a = BASE + SIZE - $urandom_range(0, 4);
                4:       a = BASE - $urandom_range(1, 4);
                default: a = (1'($urandom)) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom;
            endcase
            txn(we, f3, a, $urandom, 1'b0, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
